// File: rtl/stm1_vc4_deframer.sv
// STM-1 receive deframer with fixed-position VC-4 / C-4 demapping.
// Acquires A1/A2 framing (HUNT -> PRESYNC -> SYNC), tracks row/col of the
// 270x9 frame and, while in SYNC, emits the POH column (col 9) and the
// 260x9 C-4 payload (cols 10..269). All outputs are registered.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid, in_data[7:0]         line byte stream (one byte per accepted cycle)
//   out_valid, out_data[7:0]       C-4 payload byte
//   out_row[3:0], out_col[8:0]     C-4 position (row 0..8, col 0..259)
//   out_sof, out_eof               first / last C-4 byte of a frame
//   poh_valid, poh_data[7:0]       VC-4 POH byte
//   poh_row[3:0]                   POH row 0..8
//   in_frame                       frame alignment held (SYNC)
//   frame_err                      one-cycle pulse on a failed check in SYNC
module stm1_vc4_deframer #(
    parameter int          STM1_LENGTH = 270,
    parameter int          STM1_WIDTH  = 9,
    parameter int          SOH_COLS    = 9,
    parameter logic [7:0]  A1_BYTE     = 8'hF6,
    parameter logic [7:0]  A2_BYTE     = 8'h28,
    parameter int          SYNC_COUNT  = 2,
    parameter int          LOSS_COUNT  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [3:0] out_row,
    output logic [8:0] out_col,
    output logic       out_sof,
    output logic       out_eof,
    output logic       poh_valid,
    output logic [7:0] poh_data,
    output logic [3:0] poh_row,
    output logic       in_frame,
    output logic       frame_err
);
    localparam logic [8:0]  LAST_COL  = 9'(STM1_LENGTH - 1);
    localparam logic [3:0]  LAST_ROW  = 4'(STM1_WIDTH - 1);
    localparam logic [8:0]  POH_COL   = 9'(SOH_COLS);
    localparam logic [8:0]  C4_COL0   = 9'(SOH_COLS + 1);
    localparam logic [8:0]  CHECK_COL = 9'd5;      // last A2 byte
    localparam logic [3:0]  SYNC_CNT  = 4'(SYNC_COUNT);
    localparam logic [3:0]  LOSS_CNT  = 4'(LOSS_COUNT);
    localparam logic [47:0] PATTERN   = {A1_BYTE, A1_BYTE, A1_BYTE,
                                         A2_BYTE, A2_BYTE, A2_BYTE};

    typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

    state_t      state, state_nxt;
    logic [8:0]  col, col_nxt;
    logic [3:0]  row, row_nxt;
    logic [47:0] shreg, shreg_nxt;
    logic [3:0]  hit, hit_nxt, err, err_nxt;
    logic        pat_ok, at_check, check_bad, emit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            col   <= '0;
            row   <= '0;
            shreg <= '0;
            hit   <= '0;
            err   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            shreg <= shreg_nxt;
            hit   <= hit_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        shreg_nxt = shreg;
        hit_nxt   = hit;
        err_nxt   = err;
        check_bad = 1'b0;
        // pattern test includes the byte being accepted now
        pat_ok    = ({shreg[39:0], in_data} == PATTERN);
        at_check  = (row == 4'd0) && (col == CHECK_COL);
        if (in_valid) begin
            shreg_nxt = {shreg[39:0], in_data};
            if (col == LAST_COL) begin
                col_nxt = '0;
                row_nxt = (row == LAST_ROW) ? 4'd0 : row + 4'd1;
            end else begin
                col_nxt = col + 9'd1;
            end
            unique case (state)
                HUNT: begin
                    if (pat_ok) begin
                        // this byte is row 0 col 5; next one is col 6
                        col_nxt   = CHECK_COL + 9'd1;
                        row_nxt   = 4'd0;
                        hit_nxt   = 4'd1;
                        err_nxt   = 4'd0;
                        state_nxt = (SYNC_CNT == 4'd1) ? SYNC : PRESYNC;
                    end
                end
                PRESYNC: begin
                    if (at_check) begin
                        if (pat_ok) begin
                            hit_nxt = hit + 4'd1;
                            if (hit + 4'd1 >= SYNC_CNT) begin
                                state_nxt = SYNC;
                                err_nxt   = 4'd0;
                            end
                        end else begin
                            state_nxt = HUNT;
                            shreg_nxt = '0;
                        end
                    end
                end
                SYNC: begin
                    if (at_check) begin
                        if (pat_ok) begin
                            err_nxt = 4'd0;
                        end else begin
                            check_bad = 1'b1;
                            err_nxt   = err + 4'd1;
                            if (err + 4'd1 >= LOSS_CNT) begin
                                state_nxt = HUNT;
                                shreg_nxt = '0;
                            end
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // output decision uses the state the byte was accepted in
    assign emit = in_valid && (state == SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            poh_valid <= 1'b0;
            poh_data  <= '0;
            poh_row   <= '0;
            in_frame  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            poh_valid <= 1'b0;
            frame_err <= check_bad;
            in_frame  <= (state_nxt == SYNC);
            if (emit && col >= C4_COL0) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_row   <= row;
                out_col   <= col - C4_COL0;
                out_sof   <= (row == 4'd0) && (col == C4_COL0);
                out_eof   <= (row == LAST_ROW) && (col == LAST_COL);
            end else if (emit && col == POH_COL) begin
                poh_valid <= 1'b1;
                poh_data  <= in_data;
                poh_row   <= row;
            end
        end
    end
endmodule

// File: tb/tb_stm1_vc4_deframer.sv
// Randomized bench for stm1_vc4_deframer: frame-level reference model
// (linear frame position, byte queue for framing) compared every cycle.
module tb_stm1_vc4_deframer;
    localparam logic [7:0] A1 = 8'hF6;
    localparam logic [7:0] A2 = 8'h28;
    localparam int FRAME = 2430;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid, out_sof, out_eof, poh_valid, in_frame, frame_err;
    logic [7:0] out_data, poh_data;
    logic [3:0] out_row, poh_row;
    logic [8:0] out_col;

    stm1_vc4_deframer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_sof(out_sof), .out_eof(out_eof),
        .poh_valid(poh_valid), .poh_data(poh_data), .poh_row(poh_row),
        .in_frame(in_frame), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_ov = 0, n_sof = 0, n_eof = 0, n_pv = 0, n_fe = 0;
    int rec_sel = 0;
    int t1_q[$], t5_q[$];
    bit gaps = 1'b0;

    // ---------------- reference model ----------------
    int         m_pos = 0, m_mode = 0, m_hits = 0, m_errs = 0; // mode 0 hunt,1 presync,2 sync
    logic [7:0] m_q[$];
    logic       e_ov = 0, e_sof = 0, e_eof = 0, e_pv = 0, e_if = 0, e_fe = 0;
    logic [7:0] e_od = 0, e_pd = 0;
    int         e_or = 0, e_oc = 0, e_pr = 0;

    task automatic model_byte(input logic [7:0] b);
        int r, c;
        bit pat, is_chk;
        r = m_pos / 270;
        c = m_pos % 270;
        is_chk = (m_pos == 5);
        m_q.push_back(b);
        if (m_q.size() > 6) void'(m_q.pop_front());
        pat = (m_q.size() == 6) && m_q[0] == A1 && m_q[1] == A1 && m_q[2] == A1
              && m_q[3] == A2 && m_q[4] == A2 && m_q[5] == A2;
        if (m_mode == 2) begin
            if (c >= 10) begin
                e_ov = 1; e_od = b; e_or = r; e_oc = c - 10;
                e_sof = (m_pos == 10); e_eof = (m_pos == FRAME - 1);
            end else if (c == 9) begin
                e_pv = 1; e_pd = b; e_pr = r;
            end
        end
        m_pos = (m_pos + 1) % FRAME;
        if (m_mode == 0) begin
            if (pat) begin m_pos = 6; m_hits = 1; m_mode = 1; end
        end else if (is_chk) begin
            if (m_mode == 1) begin
                if (pat) begin
                    m_hits++;
                    if (m_hits == 2) begin m_mode = 2; m_errs = 0; end
                end else begin
                    m_mode = 0; m_q.delete();
                end
            end else if (pat) begin
                m_errs = 0;
            end else begin
                e_fe = 1; m_errs++;
                if (m_errs == 4) begin m_mode = 0; m_q.delete(); end
            end
        end
        e_if = (m_mode == 2);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pos = 0; m_mode = 0; m_hits = 0; m_errs = 0; m_q.delete();
            e_ov = 0; e_sof = 0; e_eof = 0; e_pv = 0; e_if = 0; e_fe = 0;
        end else begin
            e_ov = 0; e_pv = 0; e_fe = 0; e_sof = 0; e_eof = 0;
            if (in_valid) model_byte(in_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        total++;
        if ({out_valid, poh_valid, frame_err, in_frame} !== {e_ov, e_pv, e_fe, e_if}) begin
            bad++;
            $display("FAIL ctl t=%0t got ov,pv,fe,if=%b%b%b%b want %b%b%b%b", $time,
                     out_valid, poh_valid, frame_err, in_frame, e_ov, e_pv, e_fe, e_if);
        end
        if (e_ov) begin
            total++;
            if (out_data !== e_od || out_row !== 4'(e_or) || out_col !== 9'(e_oc)
                || out_sof !== e_sof || out_eof !== e_eof) begin
                bad++;
                $display("FAIL c4 t=%0t got d=%h r=%0d c=%0d sof=%b eof=%b want d=%h r=%0d c=%0d sof=%b eof=%b",
                         $time, out_data, out_row, out_col, out_sof, out_eof,
                         e_od, e_or, e_oc, e_sof, e_eof);
            end
        end
        if (e_pv) begin
            total++;
            if (poh_data !== e_pd || poh_row !== 4'(e_pr)) begin
                bad++;
                $display("FAIL poh t=%0t got d=%h r=%0d want d=%h r=%0d",
                         $time, poh_data, poh_row, e_pd, e_pr);
            end
        end
        if (out_valid) begin
            n_ov++;
            if (out_sof) n_sof++;
            if (out_eof) n_eof++;
            if (rec_sel == 1) t1_q.push_back({out_row, out_col, out_data});
            if (rec_sel == 5) t5_q.push_back({out_row, out_col, out_data});
        end
        if (poh_valid) n_pv++;
        if (frame_err) n_fe++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int r, input int c);
        if (r == 0 && c < 3) return A1;
        if (r == 0 && c < 6) return A2;
        if (c < 9) return 8'h00;
        if (c == 9) return 8'hA0 + 8'(r);
        return 8'((r * 260 + c - 10) & 255);
    endfunction

    task automatic send(input logic [7:0] b);
        if (gaps) while ($urandom_range(0, 99) < 30) begin
            @(negedge clk); in_valid = 1'b0;
        end
        @(negedge clk); in_valid = 1'b1; in_data = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); in_valid = 1'b0; end
    endtask

    task automatic frame(input bit bad4);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 270; c++)
                send((bad4 && r == 0 && c == 4) ? 8'h00 : fbyte(r, c));
    endtask

    // random bytes never equal to A1, so no accidental framing pattern
    task automatic junk(input int n);
        repeat (n) send(8'($urandom_range(0, 200)));
    endtask

    task automatic do_reset(input string name);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk({name, " outputs zero"}, int'(|{out_valid, out_data, out_row, out_col, out_sof,
             out_eof, poh_valid, poh_data, poh_row, in_frame, frame_err}), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_ov, b_sof, b_eof, b_pv, b_fe;
        // Test 1: junk + 3 clean frames
        do_reset("t1 reset");
        b_ov = n_ov; b_sof = n_sof; b_eof = n_eof; b_pv = n_pv; b_fe = n_fe;
        rec_sel = 1;
        junk(37);
        frame(0);
        idle(1);
        chk("t1 no output frame1", n_ov - b_ov, 0);
        chk("t1 in_frame after frame1", int'(in_frame), 0);
        frame(0); frame(0);
        idle(2);
        rec_sel = 0;
        chk("t1 out_valid count", n_ov - b_ov, 4680);
        chk("t1 sof count", n_sof - b_sof, 2);
        chk("t1 eof count", n_eof - b_eof, 2);
        chk("t1 poh count", n_pv - b_pv, 18);
        chk("t1 frame_err count", n_fe - b_fe, 0);
        chk("t1 first byte", t1_q.size() > 0 ? t1_q[0] : -1, 0);
        chk("t1 last byte", t1_q.size() > 0 ? t1_q[t1_q.size()-1] : -1,
            (8 << 17) | (259 << 8) | ((8 * 260 + 259) & 255));

        // Test 2: isolated pattern, never repeated
        do_reset("t2 reset");
        b_ov = n_ov;
        junk(100);
        send(A1); send(A1); send(A1); send(A2); send(A2); send(A2);
        idle(1);
        chk("t2 model presync", m_mode, 1);
        junk(2500);
        idle(2);
        chk("t2 model back to hunt", m_mode, 0);
        chk("t2 in_frame", int'(in_frame), 0);
        chk("t2 out_valid count", n_ov - b_ov, 0);

        // Test 3: 3 corrupt frames in SYNC, then clean
        do_reset("t3 reset");
        b_fe = n_fe; b_eof = n_eof;
        frame(0); frame(0);
        frame(1); frame(1); frame(1);
        frame(0);
        idle(2);
        chk("t3 frame_err count", n_fe - b_fe, 3);
        chk("t3 in_frame held", int'(in_frame), 1);
        chk("t3 eof count", n_eof - b_eof, 5);

        // Test 4: 4 corrupt frames -> loss, then reacquire
        do_reset("t4 reset");
        b_fe = n_fe; b_eof = n_eof;
        frame(0); frame(0);
        frame(1); frame(1); frame(1); frame(1);
        idle(2);
        chk("t4 in_frame lost", int'(in_frame), 0);
        chk("t4 frame_err count", n_fe - b_fe, 4);
        frame(0);
        idle(1);
        chk("t4 not yet synced", int'(in_frame), 0);
        frame(0);
        idle(2);
        chk("t4 reacquired", int'(in_frame), 1);
        chk("t4 eof count", n_eof - b_eof, 5);

        // Test 5: test-1 stream with 30% idle cycles
        do_reset("t5 reset");
        gaps = 1'b1;
        rec_sel = 5;
        junk(37);
        frame(0); frame(0); frame(0);
        idle(2);
        rec_sel = 0;
        gaps = 1'b0;
        chk("t5 seq length", t5_q.size(), t1_q.size());
        begin
            int diffs = 0;
            for (int i = 0; i < t5_q.size() && i < t1_q.size(); i++)
                if (t5_q[i] != t1_q[i]) diffs++;
            chk("t5 seq equals t1", diffs, 0);
        end

        // Test 6: POH values, mid-frame reset, reacquire
        do_reset("t6 reset");
        frame(0); frame(0);
        for (int i = 0; i < 1200; i++) send(fbyte(i / 270, i % 270));
        chk("t6 in_frame before reset", int'(in_frame), 1);
        do_reset("t6 midframe reset");
        b_ov = n_ov; b_pv = n_pv;
        frame(0);
        idle(1);
        chk("t6 in_frame after 1 pattern", int'(in_frame), 0);
        frame(0);
        idle(2);
        chk("t6 reacquired", int'(in_frame), 1);
        chk("t6 poh count", n_pv - b_pv, 9);
        chk("t6 out_valid count", n_ov - b_ov, 2340);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
